// File: rtl/chnl_tx_framer.sv
// chnl_tx_framer: packs 32-bit records into fixed CHNL_ALIGN-word frames (header, payload, padding)
//   clk, rst (async, active-high)
//   i_val/i_rdy/i_data/i_last : record word input, i_last marks the final word of a record
//   o_val/o_rdy/o_data        : frame word output toward the CHNL transmitter
//   o_frame_cnt               : completed frame count (wraps)
//   CHNL_TX_FRAMER_FLUSH_EN   : when defined, a partial frame is flushed after MAX_IDLE_CYCLES idle cycles
module chnl_tx_framer #(
  parameter int          CHNL_ALIGN      = 4,
  parameter logic [7:0]  MAGIC           = 8'hA5,
  parameter logic [31:0] PAD_WORD        = 32'h0000_0000,
  parameter int          MAX_IDLE_CYCLES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_val,
  output logic        i_rdy,
  input  logic [31:0] i_data,
  input  logic        i_last,
  output logic        o_val,
  input  logic        o_rdy,
  output logic [31:0] o_data,
  output logic [31:0] o_frame_cnt
);
  localparam logic [15:0] FULL     = 16'(CHNL_ALIGN - 1);
  localparam logic [15:0] LAST_IDX = 16'(CHNL_ALIGN - 2);
  typedef enum logic [1:0] {S_FILL, S_HDR, S_BODY} state_t;
  state_t state, state_nx;
  logic [31:0] mem [CHNL_ALIGN-1];
  logic [15:0] wcnt, idx;
  logic [6:0]  seq;
  logic        lastf, take, close, flush, done;
  logic [31:0] rd;
  if (CHNL_ALIGN < 2 || MAX_IDLE_CYCLES < 1) begin : g_bad_params
    $error("chnl_tx_framer: CHNL_ALIGN must be >= 2 and MAX_IDLE_CYCLES >= 1");
  end
  assign take  = state == S_FILL && i_val;
  assign close = take && (i_last || wcnt + 16'd1 == FULL);
  assign done  = state == S_BODY && o_rdy && idx == LAST_IDX;
`ifdef CHNL_TX_FRAMER_FLUSH_EN
  logic [31:0] idle;
  // flush at the end of the idle cycle that brings the counter to the limit
  assign flush = state == S_FILL && wcnt != 16'd0 && !i_val && idle == 32'(MAX_IDLE_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) idle <= '0;
    else if (state != S_FILL || take) idle <= '0;
    else if (wcnt != 16'd0 && idle != 32'(MAX_IDLE_CYCLES)) idle <= idle + 32'd1;
`else
  assign flush = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_FILL;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    i_rdy    = 1'b0;
    o_val    = 1'b0;
    o_data   = '0;
    rd       = PAD_WORD;
    for (int k = 0; k < CHNL_ALIGN - 1; k++)
      if (idx == 16'(k) && idx < wcnt) rd = mem[k];
    case (state)
      S_FILL: begin
        i_rdy    = 1'b1;
        state_nx = (close || flush) ? S_HDR : S_FILL;
      end
      S_HDR: begin
        o_val    = 1'b1;
        o_data   = {MAGIC, lastf, seq, wcnt};
        state_nx = o_rdy ? S_BODY : S_HDR;
      end
      S_BODY: begin
        o_val    = 1'b1;
        o_data   = rd;
        state_nx = done ? S_FILL : S_BODY;
      end
      default: state_nx = S_FILL;
    endcase
  end
  always_ff @(posedge clk)
    if (take)
      for (int k = 0; k < CHNL_ALIGN - 1; k++)
        if (wcnt == 16'(k)) mem[k] <= i_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt        <= '0;
      idx         <= '0;
      seq         <= '0;
      lastf       <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      if (take) wcnt <= wcnt + 16'd1;
      if (close) lastf <= i_last;
      if (flush) lastf <= 1'b0;
      if (state == S_HDR && o_rdy) idx <= '0;
      if (state == S_BODY && o_rdy) idx <= idx + 16'd1;
      if (done) begin
        wcnt        <= '0;
        seq         <= seq + 7'd1;
        o_frame_cnt <= o_frame_cnt + 32'd1;
      end
    end
endmodule

// File: tb/tb_chnl_tx_framer.sv
// tb_chnl_tx_framer: directed and randomized checks of chnl_tx_framer against a frame-level model
module tb_chnl_tx_framer;
  localparam int CA = 4;
  logic        clk = 1'b0, rst = 1'b1, i_val = 1'b0, i_last = 1'b0, o_rdy = 1'b0, rnd_rdy = 1'b0;
  logic        i_rdy, o_val;
  logic [31:0] i_data = '0, o_data, o_frame_cnt;
  logic [31:0] got[$], exp_q[$], w[$];
  logic [6:0]  seq_m = '0;
  int          frames_m = 0, total = 0, bad = 0, hi;

  chnl_tx_framer #(.CHNL_ALIGN(CA)) dut (
    .clk(clk), .rst(rst), .i_val(i_val), .i_rdy(i_rdy), .i_data(i_data), .i_last(i_last),
    .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (o_val && o_rdy) got.push_back(o_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) o_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic model_frame(input logic [31:0] c[$], input logic l);
    exp_q.push_back({8'hA5, l, seq_m, 16'(c.size())});
    foreach (c[j]) exp_q.push_back(c[j]);
    for (int j = c.size(); j < CA - 1; j++) exp_q.push_back(32'h0);
    seq_m = seq_m + 7'd1;
    frames_m++;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    i_val = 1'b1; i_data = d; i_last = l;
    while (!i_rdy && n < 500) begin step(); n++; end
    step();
    i_val = 1'b0; i_last = 1'b0;
    chk("send_timeout", 32'(n < 500), 32'd1);
  endtask

  task automatic send_rec(input logic [31:0] r[$], input int gap);
    logic [31:0] c[$];
    for (int s = 0; s < r.size(); s += CA - 1) begin
      c.delete();
      for (int j = s; j < s + CA - 1 && j < r.size(); j++) c.push_back(r[j]);
      model_frame(c, s + c.size() == r.size());
    end
    for (int j = 0; j < r.size(); j++) begin
      send(r[j], j == r.size() - 1);
      repeat ($urandom_range(0, gap)) step();
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((o_val || got.size() != exp_q.size()) && n < 3000) begin step(); n++; end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_nwords"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_frame_cnt"}, o_frame_cnt, 32'(frames_m));
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    got.delete();
    exp_q.delete();
    seq_m = '0;
    frames_m = 0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_o_val", 32'(o_val), 32'd0);
    chk("rst_i_rdy", 32'(i_rdy), 32'd1);
    chk("rst_o_data", o_data, 32'h0);
    chk("rst_frame_cnt", o_frame_cnt, 32'h0);
    // single-word record, header must follow the closing handshake by one cycle
    o_rdy = 1'b1;
    w = {32'h11};
    model_frame(w, 1'b1);
    send(32'h11, 1'b1);
    chk("single_hdr_val", 32'(o_val), 32'd1);
    chk("single_hdr", o_data, 32'hA580_0001);
    wait_drain();
    compare_q("single");
    // five-word record split into two frames
    do_reset();
    w = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    send_rec(w, 0);
    wait_drain();
    chk("split_hdr1", got[0], 32'hA500_0003);
    chk("split_hdr2", got[4], 32'hA581_0002);
    compare_q("split");
    // backpressure on body word 1
    o_rdy = 1'b0;
    w = {32'hAAAA_0000, 32'hBBBB_1111, 32'hCCCC_2222};
    send_rec(w, 0);
    o_rdy = 1'b1;
    step();
    step();
    o_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_val", 32'(o_val), 32'd1);
      chk("bp_data", o_data, 32'hBBBB_1111);
      chk("bp_i_rdy", 32'(i_rdy), 32'd0);
      step();
    end
    o_rdy = 1'b1;
    wait_drain();
    compare_q("bp");
    // sequence number wrap
    do_reset();
    for (int i = 0; i < 129; i++) begin
      w = {32'(i)};
      send_rec(w, 0);
    end
    wait_drain();
    chk("wrap_hdr127", got[127*CA], 32'hA5FF_0001);
    chk("wrap_hdr128", got[128*CA], 32'hA580_0001);
    chk("wrap_cnt", o_frame_cnt, 32'd129);
    compare_q("wrap");
    // idle behaviour with a partial frame
    do_reset();
    send(32'h0000_0A0A, 1'b0);
    send(32'h0000_0B0B, 1'b0);
`ifdef CHNL_TX_FRAMER_FLUSH_EN
    w = {32'h0000_0A0A, 32'h0000_0B0B};
    model_frame(w, 1'b0);
    repeat (127) step();
    chk("flush_early", 32'(o_val), 32'd0);
    step();
    chk("flush_val", 32'(o_val), 32'd1);
    chk("flush_hdr", o_data, 32'hA500_0002);
    wait_drain();
    w = {32'h0000_0C0C};
    model_frame(w, 1'b1);
    send(32'h0000_0C0C, 1'b1);
`else
    hi = 0;
    repeat (1000) begin
      step();
      if (o_val) hi++;
    end
    chk("noflush_idle", 32'(hi), 32'd0);
    w = {32'h0000_0A0A, 32'h0000_0B0B, 32'h0000_0C0C};
    model_frame(w, 1'b1);
    send(32'h0000_0C0C, 1'b1);
    chk("noflush_hdr", o_data, 32'hA580_0003);
`endif
    wait_drain();
    compare_q("idle");
    // reset during body word 2
    w = {32'h1234_0001, 32'h1234_0002, 32'h1234_0003};
    send_rec(w, 0);
    step();
    step();
    step();
    chk("mid_body_w2", o_data, 32'h1234_0003);
    rst = 1'b1;
    #1;
    chk("midrst_o_val", 32'(o_val), 32'd0);
    chk("midrst_i_rdy", 32'(i_rdy), 32'd1);
    chk("midrst_cnt", o_frame_cnt, 32'd0);
    chk("midrst_o_data", o_data, 32'h0);
    do_reset();
    w = {32'h77};
    model_frame(w, 1'b1);
    send(32'h77, 1'b1);
    chk("postrst_hdr", o_data, 32'hA580_0001);
    wait_drain();
    compare_q("postrst");
    // randomized records, gaps and downstream stalls
    rnd_rdy = 1'b1;
    for (int r = 0; r < 30; r++) begin
      w.delete();
      for (int j = 0, n = $urandom_range(1, 9); j < n; j++) w.push_back($urandom);
      send_rec(w, 3);
    end
    wait_drain();
    rnd_rdy = 1'b0;
    o_rdy = 1'b1;
    compare_q("rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
